// File: rtl/access_input_collector.sv
// rtl/access_input_collector.sv - keypad hex entry collector emitting {mode, digits} words
module access_input_collector #(
  parameter int DIGITS      = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            digit_in,
  input  logic                  digit_valid,
  input  logic                  enter_btn,
  input  logic                  clear_btn,
  input  logic [1:0]            mode_sel,
  output logic [DIGITS*4+1:0]   data_out,
  output logic                  data_load,
  output logic [2:0]            digit_count,
  output logic                  entry_error,
  output logic                  busy
);

  localparam int          W    = DIGITS * 4;
  localparam logic [2:0]  FULL = 3'(DIGITS);
  localparam logic [3:0]  HOLD = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t       state_q;
  logic [W-1:0] shift_q;
  logic [2:0]   count_q;
  logic         ovf_q;
  logic         err_q;
  logic         load_q;
  logic         busy_q;
  logic         clr_pend_q;
  logic [W+1:0] dout_q;
  logic [3:0]   hold_q;

  logic         sync1_q;
  logic         sync2_q;
  logic         sync3_q;
  logic         enter_q;
  logic         enter_rise_d;

  // Rising edge of the synchronised enter level; registered below so the
  // FSM sees a clean one-cycle event three edges after the button is sampled.
  assign enter_rise_d = sync2_q & ~sync3_q;

  // Two-flop synchroniser, edge history flop and registered enter event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      sync1_q <= enter_btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      enter_q <= enter_rise_d;
    end
  end

  // Entry FSM with registered outputs: collect digits, emit, then hold off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      clr_pend_q <= 1'b0;
      dout_q     <= '0;
      hold_q     <= '0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (clear_btn) begin
            shift_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (enter_q) begin
            // Enter wins over a simultaneous digit; the digit is dropped.
            if (count_q == FULL && !ovf_q) begin
              dout_q  <= {mode_sel, shift_q};
              load_q  <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_EMIT;
            end else begin
              err_q   <= 1'b1;
              shift_q <= '0;
              count_q <= '0;
              ovf_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (digit_valid) begin
            if (count_q < FULL) begin
              shift_q <= {shift_q[W-5:0], digit_in};
              count_q <= count_q + 3'd1;
              err_q   <= 1'b0;
              state_q <= S_COLLECT;
            end else begin
              // Extra digit: discarded, and the entry can no longer be emitted.
              err_q <= 1'b1;
              ovf_q <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          // A clear seen here is remembered and applied in the first HOLD cycle.
          shift_q    <= '0;
          count_q    <= '0;
          ovf_q      <= 1'b0;
          hold_q     <= HOLD;
          clr_pend_q <= clear_btn;
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (clear_btn || clr_pend_q) begin
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= '0;
            state_q    <= S_IDLE;
          end else if (hold_q <= 4'd1) begin
            busy_q  <= 1'b0;
            hold_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out    = dout_q;
  assign data_load   = load_q;
  assign digit_count = count_q;
  assign entry_error = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_access_input_collector.sv
// tb/tb_access_input_collector.sv - directed self-checking bench for access_input_collector
module tb_access_input_collector;

  localparam int HOLD_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        enter_btn;
  logic        clear_btn;
  logic [1:0]  mode_sel;
  logic [17:0] data_out;
  logic        data_load;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int load_total = 0;
  int busy_total = 0;
  int load_base;
  int busy_base;

  access_input_collector #(.DIGITS(4), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .enter_btn   (enter_btn),
    .clear_btn   (clear_btn),
    .mode_sel    (mode_sel),
    .data_out    (data_out),
    .data_load   (data_load),
    .digit_count (digit_count),
    .entry_error (entry_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Count strobe and busy cycles midway between active edges.
  always @(negedge clk) begin
    if (data_load === 1'b1) load_total <= load_total + 1;
    if (busy === 1'b1) busy_total <= busy_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  // Enter held two cycles; FSM acts at the 4th edge from the first sample.
  task automatic enter_pulse();
    enter_btn = 1'b1;
    tick();
    tick();
    enter_btn = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; digit_in = 4'h0; digit_valid = 1'b0;
    enter_btn = 1'b0; clear_btn = 1'b0; mode_sel = 2'b00;
    tick(); tick();
    check("rst_data_out", data_out, 18'h0);
    check("rst_load", {17'h0, data_load}, 18'h0);
    check("rst_count", {15'h0, digit_count}, 18'h0);
    check("rst_error", {17'h0, entry_error}, 18'h0);
    check("rst_busy", {17'h0, busy}, 18'h0);
    rst = 1'b0;
    tick();

    // Normal entry 1,2,3,4 with enter held 10 cycles
    mode_sel = 2'b01;
    press_digit(4'h1); press_digit(4'h2); press_digit(4'h3); press_digit(4'h4);
    check("s1_count4", {15'h0, digit_count}, 18'd4);
    load_base = load_total; busy_base = busy_total;
    enter_btn = 1'b1;
    tick(); tick(); tick();
    check("s1_no_load_early", {17'h0, data_load}, 18'h0);
    tick();
    check("s1_load_latency", {17'h0, data_load}, 18'h1);
    check("s1_data_out", data_out, 18'h11234);
    check("s1_busy_emit", {17'h0, busy}, 18'h1);
    repeat (6) tick();
    enter_btn = 1'b0;
    repeat (3) tick();
    check("s1_one_load", 18'(load_total - load_base), 18'd1);
    check("s1_busy_len", 18'(busy_total - busy_base), 18'(1 + HOLD_CYCLES));
    check("s1_idle_busy", {17'h0, busy}, 18'h0);
    check("s1_count_clr", {15'h0, digit_count}, 18'h0);

    // Short entry A,B then enter
    press_digit(4'hA); press_digit(4'hB);
    check("s2_count2", {15'h0, digit_count}, 18'd2);
    load_base = load_total;
    enter_pulse();
    check("s2_error", {17'h0, entry_error}, 18'h1);
    check("s2_count0", {15'h0, digit_count}, 18'h0);
    check("s2_no_load", 18'(load_total - load_base), 18'd0);
    check("s2_data_hold", data_out, 18'h11234);

    // Overflow: digits 1..5 then enter
    press_digit(4'h1);
    check("s3_err_clr", {17'h0, entry_error}, 18'h0);
    press_digit(4'h2); press_digit(4'h3); press_digit(4'h4);
    check("s3_err_still0", {17'h0, entry_error}, 18'h0);
    press_digit(4'h5);
    check("s3_ovf_err", {17'h0, entry_error}, 18'h1);
    check("s3_ovf_count", {15'h0, digit_count}, 18'd4);
    load_base = load_total;
    enter_pulse();
    check("s3_err_after", {17'h0, entry_error}, 18'h1);
    check("s3_count0", {15'h0, digit_count}, 18'h0);
    check("s3_no_load", 18'(load_total - load_base), 18'd0);
    check("s3_data_hold", data_out, 18'h11234);

    // Digit coincides with the enter event
    press_digit(4'h9);
    check("s4_err_clr", {17'h0, entry_error}, 18'h0);
    press_digit(4'h8); press_digit(4'h7);
    load_base = load_total;
    enter_btn = 1'b1;
    tick(); tick(); tick();
    enter_btn = 1'b0;
    digit_in = 4'h6; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    check("s4_count0", {15'h0, digit_count}, 18'h0);
    check("s4_error", {17'h0, entry_error}, 18'h1);
    repeat (3) tick();
    check("s4_no_load", 18'(load_total - load_base), 18'd0);
    check("s4_data_hold", data_out, 18'h11234);

    // Reset in the 2nd HOLD cycle after emitting 0BEEF
    mode_sel = 2'b00;
    press_digit(4'hB); press_digit(4'hE); press_digit(4'hE); press_digit(4'hF);
    enter_btn = 1'b1;
    repeat (4) tick();
    enter_btn = 1'b0;
    check("s5_emit_load", {17'h0, data_load}, 18'h1);
    check("s5_emit_data", data_out, 18'h0BEEF);
    tick(); tick();
    check("s5_in_hold", {17'h0, busy}, 18'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rst_data", data_out, 18'h0);
    check("s5_rst_busy", {17'h0, busy}, 18'h0);
    check("s5_rst_load", {17'h0, data_load}, 18'h0);
    mode_sel = 2'b10;
    press_digit(4'hC); press_digit(4'h0); press_digit(4'hD); press_digit(4'hE);
    load_base = load_total;
    enter_pulse();
    check("s5_fresh_data", data_out, 18'h2C0DE);
    check("s5_fresh_load", 18'(load_total - load_base), 18'd1);
    repeat (5) tick();
    check("s5_hold_done", {17'h0, busy}, 18'h0);

    // clear_btn after 3 digits, then 0,0,0,1
    mode_sel = 2'b11;
    press_digit(4'h7); press_digit(4'h7); press_digit(4'h7);
    clear_btn = 1'b1;
    tick();
    clear_btn = 1'b0;
    check("s6_clear_count", {15'h0, digit_count}, 18'h0);
    press_digit(4'h0); press_digit(4'h0); press_digit(4'h0); press_digit(4'h1);
    load_base = load_total;
    enter_pulse();
    check("s6_data", data_out, 18'h30001);
    check("s6_load", 18'(load_total - load_base), 18'd1);

    // Still in HOLD: digits ignored, clear ends the hold early
    check("s6_hold_busy", {17'h0, busy}, 18'h1);
    press_digit(4'h5);
    check("s6_hold_ignore", {15'h0, digit_count}, 18'h0);
    clear_btn = 1'b1;
    tick();
    clear_btn = 1'b0;
    check("s6_clear_hold", {17'h0, busy}, 18'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/access_input_collector.md
ACCESS_INPUT_COLLECTOR -- requirements
Module: access_input_collector

Interface
REQ-001 Parameter: DIGITS, 4, number of hex digits per entry word; fixed at 4 (16-bit payload).
REQ-002 Parameter: HOLD_CYCLES, 4, idle cycles enforced after each emitted word; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: digit_in  input  4  hex digit value; qualified by digit_valid.
REQ-006 Port: digit_valid  input  1  one-cycle pulse per key press, synchronous to clk.
REQ-007 Port: enter_btn  input  1  raw asynchronous enter button level.
REQ-008 Port: clear_btn  input  1  synchronous level; discards the current entry.
REQ-009 Port: mode_sel  input  2  mode bits prepended to the emitted word.
REQ-010 Port: data_out  output  18  emitted word {mode_sel, digits}; holds the last emitted value.
REQ-011 Port: data_load  output  1  one-cycle strobe marking a new data_out.
REQ-012 Port: digit_count  output  3  digits collected so far, 0..4.
REQ-013 Port: entry_error  output  1  sticky error flag for a malformed entry.
REQ-014 Port: busy  output  1  high in EMIT and HOLD states.

Function
REQ-015 enter_btn SHALL pass through a 2-flop synchroniser followed by a rising-edge detector; a level held high produces exactly one enter event.
REQ-016 States SHALL be IDLE, COLLECT, EMIT and HOLD.
- IDLE: digit_count = 0.
- COLLECT: at least one digit accepted.
- EMIT: lasts one cycle.
- HOLD: lasts HOLD_CYCLES cycles.
REQ-017 In IDLE or COLLECT, a digit_valid with digit_count < 4 SHALL shift in: shift_reg <= {shift_reg[11:0], digit_in}; digit_count increments; state becomes COLLECT.
REQ-018 A digit_valid with digit_count == 4 SHALL be discarded and SHALL set entry_error; the entry is then marked overflowed.
REQ-019 An enter event with digit_count == 4 and no overflow SHALL latch data_out <= {mode_sel, shift_reg}, sampling mode_sel at the same edge, and SHALL move to EMIT.
REQ-020 data_load SHALL be high only during EMIT, exactly one cycle per accepted entry.
REQ-021 Latency: data_load SHALL rise 3 clock edges after the first edge at which enter_btn is sampled high.
REQ-022 An enter event with digit_count < 4, or on an overflowed entry, SHALL set entry_error, clear shift_reg and digit_count, return to IDLE, and leave data_out unchanged with no data_load.
REQ-023 EMIT SHALL clear shift_reg, digit_count and the overflow mark, then go to HOLD.
REQ-024 HOLD SHALL ignore digit_valid and enter events, then go to IDLE after HOLD_CYCLES cycles.
REQ-025 entry_error SHALL clear on the first accepted digit_valid of a new entry, on clear_btn, or on rst.
REQ-026 If digit_valid and an enter event occur in the same cycle, the enter event SHALL win and the digit SHALL be dropped.
REQ-027 clear_btn high in IDLE, COLLECT or HOLD SHALL clear shift_reg, digit_count, overflow and entry_error, and SHALL go to IDLE; in HOLD this ends the hold early.
REQ-028 clear_btn in EMIT SHALL NOT suppress the data_load pulse; the clear takes effect on the following cycle.
REQ-029 digit_in values 0x0..0xF SHALL all be accepted; there is no decimal range check.

Reset
REQ-030 While rst is high, the next state SHALL be IDLE and the following SHALL be cleared to 0: data_out, data_load, digit_count, entry_error, busy, shift_reg, the overflow mark, the hold counter and the synchroniser flops.
REQ-031 rst SHALL override every other input in the same cycle, including mid-EMIT and mid-HOLD; a data_load pulse in flight is cancelled.

Verification
REQ-032 Digits 1,2,3,4, mode_sel=2'b01, enter held 10 cycles -> one data_load pulse, data_out=18'h11234, busy for 1+HOLD_CYCLES cycles.
REQ-033 Digits A,B, then enter -> entry_error=1, no data_load, data_out unchanged, digit_count=0.
REQ-034 Digits 1..5, then enter -> entry_error=1 after the 5th digit, no data_load, data_out unchanged.
REQ-035 Digits 9,8,7 entered, then digit 6 in the same cycle as an enter event -> digit dropped, entry_error=1, no data_load.
REQ-036 rst asserted in the 2nd HOLD cycle after emitting 18'h0BEEF -> next cycle shows IDLE, data_out=0, busy=0; a fresh 4-digit entry emits normally.
REQ-037 clear_btn after 3 digits, then digits 0,0,0,1 and enter -> data_out={mode_sel,16'h0001} with one data_load pulse.
